dsky_tx_scheduler: RTL and testbench

Serializes CPU writes to output IO channels (DSKY display registers, telemetry words) onto the single shared UART transmit byte stream. It sits between the IO unit's channel write strobes and the UART transmitter.
- Each channel's latest 15-bit value is held as pending.
- A round-robin arbiter grants one pending channel at a time.
- The granted word is emitted as a fixed 3-byte frame over a valid/ready byte handshake.

---
 rtl/dsky_tx_scheduler_pkg.sv | 21 ++
 rtl/dsky_tx_scheduler_if.sv | 21 ++
 rtl/dsky_tx_scheduler_rr_arbiter.sv | 45 ++++
 rtl/dsky_tx_scheduler.sv | 156 +++++++++++++++
 tb/tb_dsky_tx_scheduler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dsky_tx_scheduler_pkg.sv
// Shared types and constants for the DSKY/telemetry
// UART transmit scheduler.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    HI,
    LO
  } tx_sched_state_t;

  localparam logic [2:0] FRAME_TAG = 3'b101;
  localparam int         WORD_W    = 15;

  function automatic logic [7:0] hdr_byte(
    input logic [4:0] gid
  );
    return {FRAME_TAG, gid};
  endfunction

endpackage

// File: rtl/dsky_tx_scheduler_if.sv
// Byte-wide valid/ready link from the scheduler
// to the UART transmitter.
interface dsky_tx_if;

  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_byte,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_byte,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/dsky_tx_scheduler_rr_arbiter.sv
// Round-robin grant: first request at or after ptr,
// wrapping, via a double-width masked priority encoder.
module rr_arbiter #(
  parameter int NCHAN  = 5,
  parameter int CHAN_W = $clog2(NCHAN)
) (
  input  logic [NCHAN-1:0]  req,
  input  logic [CHAN_W-1:0] ptr,
  output logic              gnt_valid,
  output logic [CHAN_W-1:0] gnt_idx
);

  logic [2*NCHAN-1:0] w_req2;
  logic [2*NCHAN-1:0] w_mask;
  logic [2*NCHAN-1:0] w_masked;
  logic               w_found;

  always_comb begin
    w_req2 = {req, req};
    w_mask = '0;
    for (int k = 0; k < 2*NCHAN; k++) begin
      w_mask[k] = (k >= int'(ptr));
    end
    w_masked = w_req2 & w_mask;
  end

  // The upper copy guarantees a hit past ptr,
  // which is how the search wraps.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = '0;
    w_found   = 1'b0;
    for (int k = 0; k < 2*NCHAN; k++) begin
      if (w_masked[k] && !w_found) begin
        w_found = 1'b1;
        if (k >= NCHAN) begin
          gnt_idx = CHAN_W'(k - NCHAN);
        end else begin
          gnt_idx = CHAN_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/dsky_tx_scheduler.sv
// Coalesces per-channel output writes and sends the
// newest value of each as a 3-byte UART frame.
module dsky_tx_scheduler
  import io_pkg::*;
#(
  parameter int NCHAN  = 5,
  parameter int CHAN_W = $clog2(NCHAN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCHAN-1:0]        chan_we,
  input  logic [NCHAN*WORD_W-1:0] chan_wdata,
  dsky_tx_if.master               tx,
  output logic                    busy,
  output logic [NCHAN-1:0]        pending,
  output logic [7:0]              overwrite_count
);

  tx_sched_state_t r_state;
  tx_sched_state_t w_next;

  logic [WORD_W-1:0] r_value [NCHAN];
  logic [NCHAN-1:0]  r_pending;
  logic [WORD_W-1:0] r_snap;
  logic [CHAN_W-1:0] r_gid;
  logic [CHAN_W-1:0] r_ptr;
  logic [7:0]        r_ovw;

  logic              w_gnt_valid;
  logic [CHAN_W-1:0] w_gnt_idx;
  logic              w_grant;
  logic              w_xfer;
  logic [5:0]        w_ovw_inc;
  logic [9:0]        w_ovw_sum;

  rr_arbiter #(
    .NCHAN  (NCHAN),
    .CHAN_W (CHAN_W)
  ) u_arb (
    .req       (r_pending),
    .ptr       (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_grant = (r_state == IDLE) && w_gnt_valid;
  assign w_xfer  = (r_state != IDLE) && tx.tx_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_gnt_valid) w_next = HDR;
      HDR:  if (w_xfer) w_next = HI;
      HI:   if (w_xfer) w_next = LO;
      LO:   if (w_xfer) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    tx.tx_valid = 1'b0;
    tx.tx_byte  = 8'h00;
    busy        = (r_state != IDLE);
    unique case (r_state)
      IDLE: ;
      HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_byte  = hdr_byte(5'(r_gid));
      end
      HI: begin
        tx.tx_valid = 1'b1;
        tx.tx_byte  = {1'b0, r_snap[14:8]};
      end
      LO: begin
        tx.tx_valid = 1'b1;
        tx.tx_byte  = r_snap[7:0];
      end
      default: ;
    endcase
  end

  // A write on the grant cycle keeps pending set so
  // the new value follows in a later frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        r_value[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (chan_we[i]) begin
          r_value[i]   <= chan_wdata[i*WORD_W +: WORD_W];
          r_pending[i] <= 1'b1;
        end else if (w_grant &&
                     w_gnt_idx == CHAN_W'(i)) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_snap <= '0;
      r_gid  <= '0;
      r_ptr  <= '0;
    end else begin
      if (w_grant) begin
        r_snap <= r_value[w_gnt_idx];
        r_gid  <= w_gnt_idx;
      end
      if (r_state == LO && w_xfer) begin
        if (r_gid == CHAN_W'(NCHAN - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= r_gid + CHAN_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_ovw_inc = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (chan_we[i] && r_pending[i] &&
          !(w_grant && w_gnt_idx == CHAN_W'(i))) begin
        w_ovw_inc = w_ovw_inc + 6'd1;
      end
    end
    w_ovw_sum = {2'b00, r_ovw} + {4'b0000, w_ovw_inc};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovw <= '0;
    end else if (w_ovw_sum > 10'd255) begin
      r_ovw <= 8'hFF;
    end else begin
      r_ovw <= w_ovw_sum[7:0];
    end
  end

  assign pending         = r_pending;
  assign overwrite_count = r_ovw;

endmodule

// File: tb/tb_dsky_tx_scheduler.sv
// Directed bench for dsky_tx_scheduler with a byte
// scoreboard fed at stimulus time.
module tb_dsky_tx_scheduler;

  localparam int NCHAN = 5;
  localparam int WW    = 15;

  logic              clk;
  logic              rst;
  logic [NCHAN-1:0]  chan_we;
  logic [NCHAN*WW-1:0] chan_wdata;
  logic              busy;
  logic [NCHAN-1:0]  pending;
  logic [7:0]        ovw;

  dsky_tx_if tx_if ();

  dsky_tx_scheduler #(.NCHAN(NCHAN)) dut (
    .clock           (clk),
    .reset           (rst),
    .chan_we         (chan_we),
    .chan_wdata      (chan_wdata),
    .tx              (tx_if),
    .busy            (busy),
    .pending         (pending),
    .overwrite_count (ovw)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int ch,
                            input logic [14:0] d);
    logic [4:0] g;
    g = 5'(ch);
    exp_q.push_back({3'b101, g});
    exp_q.push_back({1'b0, d[14:8]});
    exp_q.push_back(d[7:0]);
  endtask

  task automatic wr(input int ch, input logic [14:0] d);
    chan_we[ch] = 1'b1;
    chan_wdata[ch*WW +: WW] = d;
    @(posedge clk);
    #1 chan_we = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && pending == '0 &&
          exp_q.size() == 0) break;
    end
    chk({tag, "_qleft"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // A transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && tx_if.tx_valid && tx_if.tx_ready) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("xfer_byte", 32'(tx_if.tx_byte),
            32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    chan_we = '0;
    chan_wdata = '0;
    tx_if.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("rst_byte", 32'(tx_if.tx_byte), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_ovw", 32'(ovw), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single write, latency
    tx_if.tx_ready = 1'b1;
    push_frame(2, 15'h5A3C);
    wr(2, 15'h5A3C);
    @(negedge clk);
    chk("t1_pend", 32'(pending), 32'h04);
    chk("t1_valid0", 32'(tx_if.tx_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid1", 32'(tx_if.tx_valid), 32'd1);
    chk("t1_hdr", 32'(tx_if.tx_byte), 32'hA2);
    wait_idle("t1");
    chk("t1_pend0", 32'(pending), 32'd0);

    // all channels at once, 4-cycle frame period
    do_reset();
    tx_if.tx_ready = 1'b1;
    for (int i = 0; i < NCHAN; i++) begin
      chan_wdata[i*WW +: WW] = 15'(i + 1);
      push_frame(i, 15'(i + 1));
    end
    chan_we = '1;
    @(posedge clk);
    #1 chan_we = '0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    chk("t3_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t3_busy_done", 32'(busy), 32'd0);
    chk("t3_q", 32'(exp_q.size()), 32'd0);
    chk("t3_pend", 32'(pending), 32'd0);

    // pointer wrapped to 0 after ch4
    push_frame(0, 15'h0011);
    push_frame(4, 15'h0044);
    chan_wdata[0 +: WW]    = 15'h0011;
    chan_wdata[4*WW +: WW] = 15'h0044;
    chan_we = 5'b10001;
    @(posedge clk);
    #1 chan_we = '0;
    wait_idle("t3b");

    // stall during HI
    push_frame(3, 15'h1234);
    wr(3, 15'h1234);
    @(posedge clk);
    @(posedge clk);
    #1 tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_valid", 32'(tx_if.tx_valid), 32'd1);
      chk("t4_byte", 32'(tx_if.tx_byte), 32'h12);
    end
    tx_if.tx_ready = 1'b1;
    wait_idle("t4");

    // coalescing and overwrite count
    do_reset();
    tx_if.tx_ready = 1'b0;
    push_frame(0, 15'h0700);
    wr(0, 15'h0700);
    repeat (2) @(posedge clk);
    #1;
    wr(1, 15'h0001);
    wr(1, 15'h0002);
    chk("t5_ovw", 32'(ovw), 32'd1);
    chk("t5_pend", 32'(pending), 32'h02);
    push_frame(1, 15'h0002);
    tx_if.tx_ready = 1'b1;
    wait_idle("t5");
    chk("t5_ovw2", 32'(ovw), 32'd1);

    // write on the grant cycle
    push_frame(1, 15'h0003);
    push_frame(1, 15'h0004);
    wr(1, 15'h0003);
    wr(1, 15'h0004);
    wait_idle("t5b");
    chk("t5b_ovw", 32'(ovw), 32'd1);

    // saturation
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wr(2, 15'(i + 100));
      if (i == 254) begin
        chk("t6_ovw254", 32'(ovw), 32'd254);
      end
    end
    chk("t6_ovw_sat", 32'(ovw), 32'd255);

    // reset beats a simultaneous write
    rst = 1'b1;
    chan_we[0] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chan_we = '0;
    exp_q.delete();
    @(negedge clk);
    chk("t7_pend", 32'(pending), 32'd0);
    chk("t7_ovw", 32'(ovw), 32'd0);
    chk("t7_valid", 32'(tx_if.tx_valid), 32'd0);

    // reset in LO abandons the frame
    tx_if.tx_ready = 1'b1;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0A);
    wr(3, 15'h0ABC);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 tx_if.tx_ready = 1'b0;
    @(negedge clk);
    chk("t8_lo_valid", 32'(tx_if.tx_valid), 32'd1);
    chk("t8_lo_byte", 32'(tx_if.tx_byte), 32'hBC);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t8_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_pend", 32'(pending), 32'd0);
    chk("t8_ovw", 32'(ovw), 32'd0);
    tx_if.tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t8_q", 32'(exp_q.size()), 32'd0);
    chk("t8_idle", 32'(tx_if.tx_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
